// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and flag bit positions for multicycle_alu
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_LSH  = 4'd2;
  localparam logic [3:0] OP_RSH  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;
  localparam logic [3:0] OP_ASR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_BUSY,
    ST_HOLD
  } alu_state_e;

endpackage

// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - request/result handshake bundle for multicycle_alu
interface multicycle_alu_if #(
  parameter int WIDTH  = 16,
  parameter int FUNC_W = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [FUNC_W-1:0] func;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  z;
  logic [3:0]        flags;

  modport master (
    output in_valid, a, b, func, out_ready,
    input  in_ready, out_valid, z, flags
  );

  modport slave (
    input  in_valid, a, b, func, out_ready,
    output in_ready, out_valid, z, flags
  );

endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // done flags the final step so the caller can capture the product on the same edge
  assign done    = busy && (cnt == CNT_W'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - ALU with single-cycle ops and a sequential multiply behind a valid/ready handshake
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FUNC_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_alu_if.slave bus
);

  alu_state_e         state;
  logic [WIDTH-1:0]   z_q;
  logic [3:0]         flags_q;
  logic               out_valid_q;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [3:0]         mul_flags;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     shr;
  logic [WIDTH-1:0]   asr;
  logic               amt_big;
  logic [WIDTH-1:0]   alu_z;
  logic               alu_c;
  logic               alu_v;
  logic [3:0]         alu_flags;

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.flags     = flags_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign mul_start = accept && (bus.func == FUNC_W'(OP_MUL));

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_product[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
    mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
  end

  // The extra guard bit on each shift catches the last bit pushed out, including at amount == WIDTH
  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = {1'b0, bus.a} - {1'b0, bus.b};
    shl     = {1'b0, bus.a} << bus.b;
    shr     = {bus.a, 1'b0} >> bus.b;
    amt_big = (bus.b >= WIDTH'(WIDTH));
    asr     = amt_big ? {WIDTH{bus.a[WIDTH-1]}} : WIDTH'($signed(bus.a) >>> bus.b);
    alu_z   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.func)
      FUNC_W'(OP_ADD): begin
        alu_z = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      FUNC_W'(OP_SUB): begin
        alu_z = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      FUNC_W'(OP_LSH): begin
        alu_z = shl[WIDTH-1:0];
        alu_c = shl[WIDTH];
      end
      FUNC_W'(OP_RSH): begin
        alu_z = shr[WIDTH:1];
        alu_c = shr[0];
      end
      FUNC_W'(OP_OR):   alu_z = bus.a | bus.b;
      FUNC_W'(OP_AND):  alu_z = bus.a & bus.b;
      FUNC_W'(OP_XOR):  alu_z = bus.a ^ bus.b;
      FUNC_W'(OP_NOT):  alu_z = ~bus.a;
      FUNC_W'(OP_PASS): alu_z = bus.a;
      FUNC_W'(OP_ASR):  alu_z = asr;
      default:          alu_z = '0;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_z[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_z == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      z_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mul_start) begin
            state <= ST_MUL_BUSY;
          end else if (accept) begin
            z_q         <= alu_z;
            flags_q     <= alu_flags;
            out_valid_q <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_MUL_BUSY: begin
          if (mul_done) begin
            z_q         <= mul_product[WIDTH-1:0];
            flags_q     <= mul_flags;
            out_valid_q <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal range 4..64.
REQ-002 Parameter FUNC_W, default 4: width of the operation code.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 func  input  FUNC_W  operation code (see REQ-013).
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 z  output  WIDTH  result.
REQ-012 flags  output  4  {N, Z, C, V}: negative, zero, carry/borrow, signed overflow.

Function
REQ-013 Opcodes: ADD=0, SUB=1, LSH=2, RSH=3, OR=4, AND=5, XOR=6, NOT=7 (~a), PASS=8 (z=a), ASR=9 (arithmetic right shift), MUL=10 (low WIDTH bits of unsigned a*b); all other codes give z=0 with flags computed on that result.
REQ-014 FSM states: IDLE, MUL_BUSY, HOLD; reset state is IDLE.
REQ-015 in_ready is 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1.
REQ-016 A non-MUL op accepted in cycle n: z and flags registered, out_valid=1 from cycle n+1; next state HOLD.
REQ-017 A MUL accepted in cycle n: a and b are latched; a shift-add runs one bit per cycle for WIDTH cycles in MUL_BUSY; out_valid=1 from cycle n+WIDTH+1; next state HOLD.
REQ-018 In HOLD, z, flags and out_valid stay stable until out_ready=1; on that edge out_valid drops and the state returns to IDLE; a new request is not accepted in the same cycle.
REQ-019 Changes to a, b and func after acceptance do not affect an in-flight result.
REQ-020 Shifts use b as an unsigned amount; an amount >= WIDTH gives 0 for LSH/RSH and a replicated sign bit for ASR.
REQ-021 C: ADD carry-out; SUB borrow (1 when a<b unsigned); LSH/RSH last bit shifted out (0 if amount is 0 or >= WIDTH+1); MUL 1 if the full product exceeds WIDTH bits; otherwise 0.
REQ-022 V: signed overflow for ADD/SUB only; otherwise 0.
REQ-023 Z = (z==0); N = z[WIDTH-1]; both computed for every op.
REQ-024 All arithmetic wraps modulo 2^WIDTH.

Reset
REQ-025 When rst_n=0, regardless of clk: state=IDLE, out_valid=0, z=0, flags=0, multiplier registers=0; in_ready=1 in the first cycle after release.
REQ-026 Asserting reset mid-MUL or in HOLD discards the operation; no out_valid pulse follows.

Structure
REQ-027 Package alu_pkg holds the opcode constants, the state enum, and flag bit indices (N=3, Z=2, C=1, V=0).
REQ-028 One sub-module, alu_mul_seq: the iterative shift-add multiplier with start/done, parametrised by WIDTH, giving a 2*WIDTH product.
REQ-029 The single-cycle datapath is combinational inside multicycle_alu; only the result/flag registers and FSM are clocked.

Verification
REQ-030 WIDTH=16, ADD a=0xFFFF b=0x0001, out_ready=1 -> z=0x0000, flags Z=1 C=1 V=0 N=0, out_valid one cycle after accept.
REQ-031 SUB a=0x8000 b=0x0001 -> z=0x7FFF, V=1, C=0, N=0; SUB a=3 b=5 -> z=0xFFFE, C=1, N=1.
REQ-032 MUL a=0x0100 b=0x0100 -> out_valid exactly 17 cycles after accept, z=0x0000, C=1, Z=1; in_ready=0 throughout.
REQ-033 ASR a=0x8000 b=20 -> z=0xFFFF; LSH a=0x0001 b=16 -> z=0; RSH a=0x0003 b=1 -> z=0x0001, C=1.
REQ-034 Backpressure: out_ready=0 for 5 cycles after the result -> z, flags and out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-035 Drop rst_n during cycle 8 of a MUL -> out_valid=0, z=0 at once; after release in_ready=1 and a fresh ADD completes correctly.
